// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the pipeline hazard / stall controller.
//   - ctrl_state_e : accelerator sequencing states (RUN, WAIT, RELEASE)
//   - REG_W_DEFAULT: default register-number width
//   - pipe_ctrl_t  : bundle of the six pipeline enable/bubble/flush controls
//   - PIPE_CTRL_*  : canned control bundles for reset, normal flow, freeze,
//                    taken branch and load-use stall
//   - select_pipe_ctrl(): priority selection freeze > branch > load-use > normal
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } ctrl_state_e;

  localparam int REG_W_DEFAULT = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic idex_bubble;
    logic ifid_flush;
    logic exmem_bubble;
  } pipe_ctrl_t;

  // Values presented on the pipeline controls while rst_n is low.
  localparam pipe_ctrl_t PIPE_CTRL_RESET = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    idex_write:   1'b1,
    idex_bubble:  1'b0,
    ifid_flush:   1'b0,
    exmem_bubble: 1'b0
  };

  // No hazard: everything advances.
  localparam pipe_ctrl_t PIPE_CTRL_NORMAL = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    idex_write:   1'b1,
    idex_bubble:  1'b0,
    ifid_flush:   1'b0,
    exmem_bubble: 1'b0
  };

  // Accelerator op holds EX and everything in front of it; MEM gets NOPs.
  localparam pipe_ctrl_t PIPE_CTRL_FREEZE = '{
    pc_write:     1'b0,
    ifid_write:   1'b0,
    idex_write:   1'b0,
    idex_bubble:  1'b0,
    ifid_flush:   1'b0,
    exmem_bubble: 1'b1
  };

  // Taken branch: squash the two wrong-path instructions in IF/ID and ID.
  localparam pipe_ctrl_t PIPE_CTRL_BRANCH = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    idex_write:   1'b1,
    idex_bubble:  1'b1,
    ifid_flush:   1'b1,
    exmem_bubble: 1'b0
  };

  // Load-use: hold PC and IF/ID, insert one bubble into EX.
  localparam pipe_ctrl_t PIPE_CTRL_LOAD_USE = '{
    pc_write:     1'b0,
    ifid_write:   1'b0,
    idex_write:   1'b1,
    idex_bubble:  1'b1,
    ifid_flush:   1'b0,
    exmem_bubble: 1'b0
  };

  localparam logic ACCEL_START_RESET   = 1'b0;
  localparam logic ACCEL_TIMEOUT_RESET = 1'b0;

  // Priority: freeze > branch > load-use > normal.
  function automatic pipe_ctrl_t select_pipe_ctrl(
    input logic freeze,
    input logic branch,
    input logic load_use
  );
    pipe_ctrl_t ctrl;
    if (freeze) begin
      ctrl = PIPE_CTRL_FREEZE;
    end else if (branch) begin
      ctrl = PIPE_CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = PIPE_CTRL_LOAD_USE;
    end else begin
      ctrl = PIPE_CTRL_NORMAL;
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/accel_timer.sv
// -----------------------------------------------------------------------------
// accel_timer
// Clear/increment counter with terminal-count flag used to bound how long the
// controller waits for the accelerator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force counter to zero (has priority over inc)
//   inc        : advance counter by one
//   tc         : counter currently equals TIMEOUT-1
// -----------------------------------------------------------------------------
module accel_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next counter value: clear wins, then increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard and stall controller for the 5-stage core. Resolves load-use stalls,
// taken-branch flushes and multi-cycle accelerator ops in EX.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   ifid_rs, ifid_rt         : source registers of the instruction in ID
//   idex_memRead, idex_rd    : load flag / destination of the instruction in EX
//   branch_taken             : branch in EX resolved taken
//   accel_op_ex              : instruction in EX is an accelerator op
//   accel_done               : accelerator result valid pulse
//   pc_write, ifid_write,
//   idex_write, idex_bubble,
//   ifid_flush, exmem_bubble : pipeline controls (combinational)
//   accel_start              : registered launch pulse, first WAIT cycle only
//   accel_busy               : high while waiting for the accelerator
//   accel_timeout            : sticky flag, accelerator never answered
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W   = REG_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             accel_op_ex,
  input  logic             accel_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_bubble,
  output logic             accel_start,
  output logic             accel_busy,
  output logic             accel_timeout
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        accel_start_q;
  logic        accel_start_d;
  logic        accel_timeout_q;
  logic        accel_timeout_d;

  logic        in_wait_s;
  logic        freeze_s;
  logic        load_use_s;
  logic        timer_clr_s;
  logic        timer_inc_s;
  logic        timer_tc_s;
  pipe_ctrl_t  ctrl_s;

  assign in_wait_s = (state_q == ST_WAIT);

  // The counter restarts from zero every time WAIT is entered, and only
  // advances on WAIT cycles that did not see done.
  assign timer_clr_s = !in_wait_s;
  assign timer_inc_s = in_wait_s && !accel_done;

  accel_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_accel_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr_s),
    .inc   (timer_inc_s),
    .tc    (timer_tc_s)
  );

  // Hazard detection and control selection. The freeze covers the launch
  // cycle (accel op seen in RUN) as well as the whole WAIT period. In
  // RELEASE accel_op_ex is deliberately ignored so the op can move to MEM.
  // Register 0 is not special-cased. rst_n gates the result so the pipeline
  // sees reset values for as long as reset is held.
  always_comb begin
    freeze_s   = ((state_q == ST_RUN) && accel_op_ex) || in_wait_s;
    load_use_s = idex_memRead && ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    if (!rst_n) begin
      ctrl_s = PIPE_CTRL_RESET;
    end else begin
      ctrl_s = select_pipe_ctrl(freeze_s, branch_taken, load_use_s);
    end
  end

  // Next-state / start / timeout logic. Done beats timeout in the same cycle.
  always_comb begin
    state_d         = state_q;
    accel_start_d   = 1'b0;
    accel_timeout_d = accel_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (accel_op_ex) begin
          state_d       = ST_WAIT;
          accel_start_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (accel_done) begin
          state_d = ST_RELEASE;
        end else if (timer_tc_s) begin
          state_d         = ST_RELEASE;
          accel_timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state, launch pulse and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      accel_start_q   <= ACCEL_START_RESET;
      accel_timeout_q <= ACCEL_TIMEOUT_RESET;
    end else begin
      state_q         <= state_d;
      accel_start_q   <= accel_start_d;
      accel_timeout_q <= accel_timeout_d;
    end
  end

  assign pc_write      = ctrl_s.pc_write;
  assign ifid_write    = ctrl_s.ifid_write;
  assign idex_write    = ctrl_s.idex_write;
  assign idex_bubble   = ctrl_s.idex_bubble;
  assign ifid_flush    = ctrl_s.ifid_flush;
  assign exmem_bubble  = ctrl_s.exmem_bubble;
  assign accel_start   = accel_start_q;
  assign accel_busy    = in_wait_s;
  assign accel_timeout = accel_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed vectors for hazard_stall_ctrl with TIMEOUT=8. Each vector is applied
// just after a rising edge and its hand-computed output word is queued; a
// monitor pops and compares on the following falling edge.
// Output word: {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
//               exmem_bubble, accel_start, accel_busy, accel_timeout}
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int REG_W   = 3;
  localparam int TIMEOUT = 8;

  localparam logic [8:0] NORM = 9'b111_000_000;
  localparam logic [8:0] LU   = 9'b001_100_000;
  localparam logic [8:0] BR   = 9'b111_110_000;
  localparam logic [8:0] FRZ  = 9'b000_001_000;
  localparam logic [8:0] W1   = 9'b000_001_110;
  localparam logic [8:0] WN   = 9'b000_001_010;
  localparam logic [8:0] TO   = 9'b000_000_001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             idex_memRead;
  logic [REG_W-1:0] idex_rd;
  logic             branch_taken;
  logic             accel_op_ex;
  logic             accel_done;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             exmem_bubble;
  logic             accel_start;
  logic             accel_busy;
  logic             accel_timeout;
  logic [8:0]       act;

  string      name_q[$];
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  hazard_stall_ctrl #(
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .idex_memRead  (idex_memRead),
    .idex_rd       (idex_rd),
    .branch_taken  (branch_taken),
    .accel_op_ex   (accel_op_ex),
    .accel_done    (accel_done),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_write    (idex_write),
    .idex_bubble   (idex_bubble),
    .ifid_flush    (ifid_flush),
    .exmem_bubble  (exmem_bubble),
    .accel_start   (accel_start),
    .accel_busy    (accel_busy),
    .accel_timeout (accel_timeout)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
                exmem_bubble, accel_start, accel_busy, accel_timeout};

  // Apply one vector for the coming cycle and queue its expected outputs.
  task automatic step(input string nm, input logic rst, input logic mr,
                      input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                      input logic [REG_W-1:0] rt, input logic br,
                      input logic acc, input logic done, input logic [8:0] ex);
    @(posedge clk);
    #1;
    rst_n        = rst;
    idex_memRead = mr;
    idex_rd      = rd;
    ifid_rs      = rs;
    ifid_rt      = rt;
    branch_taken = br;
    accel_op_ex  = acc;
    accel_done   = done;
    name_q.push_back(nm);
    exp_q.push_back(ex);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    string      nm;
    logic [8:0] ex;
    if (exp_q.size() > 0) begin
      nm = name_q.pop_front();
      ex = exp_q.pop_front();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL %s: got %b expected %b", nm, act, ex);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    idex_memRead = 1'b0;
    idex_rd      = 3'd0;
    ifid_rs      = 3'd1;
    ifid_rt      = 3'd2;
    branch_taken = 1'b0;
    accel_op_ex  = 1'b0;
    accel_done   = 1'b0;

    // Reset forces outputs even with hazard/accel inputs active.
    step("reset",        1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, NORM);
    step("idle",         1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);
    // Load-use hazards.
    step("lu_rs",        1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, LU);
    step("lu_after",     1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, NORM);
    step("lu_rt",        1'b1, 1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, LU);
    step("lu_r0",        1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, LU);
    step("lu_nomatch",   1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);
    step("lu_noload",    1'b1, 1'b0, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, NORM);
    // Branch beats load-use.
    step("br_over_lu",   1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, BR);
    step("br_alone",     1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, BR);

    // Accelerator, done on 4th WAIT cycle; branch still honoured in RELEASE.
    step("acc_launch",   1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, FRZ);
    step("acc_w1",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, W1);
    step("acc_w2",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, WN);
    step("acc_w3",       1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, WN);
    step("acc_w4_done",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, WN);
    step("acc_release",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, BR);
    // Stray done outside WAIT is ignored.
    step("done_in_run",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, NORM);
    step("run_idle",     1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);

    // Done together with accel_start; load-use honoured in RELEASE.
    step("imm_launch",   1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, FRZ);
    step("imm_w1_done",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, W1);
    step("imm_rel_lu",   1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, LU);
    step("imm_run",      1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);

    // Done on the 8th WAIT cycle coincides with terminal count: no flag.
    step("tod_launch",   1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, FRZ);
    step("tod_w1",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, W1);
    for (int i = 2; i <= 7; i++) begin
      step("tod_wn",     1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, WN);
    end
    step("tod_w8_done",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, WN);
    step("tod_release",  1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, NORM);
    step("tod_run",      1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);

    // No done at all: 8 WAIT cycles, then sticky timeout.
    step("to_launch",    1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, FRZ);
    step("to_w1",        1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, W1);
    for (int i = 2; i <= 8; i++) begin
      step("to_wn",      1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, WN);
    end
    step("to_release",   1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, NORM | TO);
    step("to_run",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM | TO);
    step("to_sticky",    1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, LU | TO);

    // Asynchronous reset in the 3rd WAIT cycle.
    step("rst_launch",   1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, FRZ | TO);
    step("rst_w1",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, W1 | TO);
    step("rst_w2",       1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, WN | TO);
    step("rst_mid_wait", 1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, NORM);
    step("rst_released", 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);
    step("rst_no_start", 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, NORM);
    step("rst_relaunch", 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, FRZ);
    step("rst_relaunch_w1", 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, W1);

    // Let the monitor drain; any leftover expectation is a failure.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage CPU core; works alongside the EX-stage forwarding logic.
- Generates PC/IF-ID/ID-EX write enables, bubble and flush controls for three cases: load-use hazards, taken-branch flushes, and multi-cycle accelerator instructions in EX.
- For an accelerator instruction, launches the crypto accelerator with a start pulse, freezes the front of the pipeline until done, and aborts on timeout.

Parameters:
- REG_W, 3, register-number width.
- TIMEOUT, 255, max WAIT cycles without accel_done before abort; must be >=1.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width; derived, never overridden.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- ifid_rs  input  REG_W  source reg 1 of instruction in ID.
- ifid_rt  input  REG_W  source reg 2 of instruction in ID.
- idex_memRead  input  1  instruction in EX is a load.
- idex_rd  input  REG_W  destination reg of instruction in EX.
- branch_taken  input  1  branch resolved taken in EX.
- accel_op_ex  input  1  instruction in EX is an accelerator op.
- accel_done  input  1  accelerator result valid (1-cycle pulse).
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- idex_write  output  1  ID/EX register enable (0 holds EX).
- idex_bubble  output  1  load NOP into ID/EX.
- ifid_flush  output  1  clear IF/ID to NOP.
- exmem_bubble  output  1  load NOP into EX/MEM.
- accel_start  output  1  registered launch pulse to accelerator.
- accel_busy  output  1  high while in WAIT.
- accel_timeout  output  1  sticky error flag.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- While rst_n=0: state=RUN, counter=0, accel_start=0, accel_timeout=0. All outputs forced to reset values: pc_write=1, ifid_write=1, idex_write=1, all others 0.
- FSM states: RUN, WAIT, RELEASE.
- Freeze condition: (RUN and accel_op_ex) or WAIT. Under freeze: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, idex_bubble=0, ifid_flush=0.
- Branch (no freeze, branch_taken=1): ifid_flush=1, idex_bubble=1, enables stay 1.
- Load-use (no freeze, no branch): condition is idex_memRead and (idex_rd==ifid_rs or idex_rd==ifid_rt). Response: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1. Exactly one bubble per hazard; register 0 is not excluded.
- Priority: freeze > branch > load-use > normal. Hazard outputs are combinational from state and inputs.
- RUN -> WAIT when accel_op_ex=1. Counter cleared to 0 on entry. accel_start=1 for exactly the first WAIT cycle.
- WAIT, accel_done=1 -> RELEASE. This includes done in the same cycle as accel_start.
- WAIT, no done: counter increments. If counter==TIMEOUT-1 -> set accel_timeout, go to RELEASE. Done and timeout in the same cycle: done wins, no flag set.
- accel_done outside WAIT is ignored.
- RELEASE: freeze released for one cycle so the accelerator instruction advances to MEM. accel_op_ex is ignored here. Branch and load-use rules apply normally. Next state is RUN.
- accel_busy = (state==WAIT).
- accel_timeout stays set until reset.
- Reset mid-WAIT: FSM returns to RUN immediately; no accel_start is reissued.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (RUN, WAIT, RELEASE);
  - REG_W default;
  - the bubble/enable reset-value constants.
- Sub-module accel_timer: clear/increment counter with terminal-count output, parameterized by TIMEOUT. Remaining logic stays in hazard_stall_ctrl.

Test Plan:
- Load-use: idex_memRead=1, idex_rd=3, ifid_rs=3 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle. Normal enables next cycle once idex_memRead drops.
- Branch vs load-use: branch_taken=1 with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1.
- Accel normal: accel_op_ex=1 in RUN, accel_done on 4th WAIT cycle -> accel_start high 1 cycle, accel_busy high 4 cycles, freeze through WAIT, RELEASE for 1 cycle with accel_op_ex still 1 and no restart, then RUN.
- Timeout: TIMEOUT=8, accel_done never asserted -> 8 WAIT cycles, accel_timeout=1 and sticky, then RELEASE then RUN. Same run with done on the 8th cycle -> no flag.
- Immediate done: accel_done in first WAIT cycle (with accel_start) -> RELEASE next cycle.
- Async reset mid-WAIT: drop rst_n at 3rd WAIT cycle -> outputs immediately at reset values. After release, state RUN, accel_busy=0, accel_timeout=0.
